stream_relay: RTL and testbench
===============================

# stream_relay

Parametrised single-channel streaming actor for the visual-saliency pipeline. It accepts tokens on an input port, optionally decimates them by a fixed factor, and buffers the kept tokens in a small FIFO. The FIFO decouples the input from output back-pressure. It replaces the fixed 16-bit, zero-buffer pass-through actors between pyramid stages and uses the same SEND/ACK/RDY/COUNT token protocol.

## Interface
- DATA_W, 16: token width in bits.
- DEPTH, 4: FIFO depth in tokens; power of two, ≥ 2.
- DECIM, 1: keep one token in DECIM; range 1..255; 1 = pure relay.

- CLK  in  1  clock, rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- In_DATA  in  DATA_W  input token.
- In_SEND  in  1  producer has a token on In_DATA.
- In_COUNT  in  16  producer token count; ignored.
- In_ACK  out  1  input token consumed this cycle.
- Out_DATA  out  DATA_W  FIFO head token.
- Out_SEND  out  1  output token transferred this cycle.
- Out_RDY  in  1  consumer can accept a token this cycle.
- Out_ACK  in  1  ignored; kept for protocol compatibility.
- Out_COUNT  out  16  constant 16'h1.

## Operation
- Start-up FSM states:
  - RST: while RESET is high.
  - KICK1, KICK2: one cycle each after RESET falls.
  - RUN.
- In_ACK and Out_SEND are 0 in every state except RUN. RESET from any state returns to RST.
- Phase counter `ph`, 0..DECIM-1, advances on each In_ACK and wraps to 0 after DECIM-1.
- In_ACK = RUN & In_SEND & (ph≠0 | ~full).
  - Tokens with ph≠0 are dropped and never wait for space.
  - A token with ph=0 is pushed into the FIFO.
- Out_SEND = RUN & ~empty & Out_RDY. Out_SEND pops the head entry.
- Out_DATA always shows the head entry. It is don't-care when empty, but must hold its last value (no X).
- Full FIFO with a simultaneous pop: the push is refused that cycle. There is no combinational path from Out_RDY to In_ACK.
- Empty FIFO: no pop. A push in that cycle is visible at the head the next cycle.
- Occupancy counter width is clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- Reset mid-stream discards all buffered tokens and clears `ph`.

## Timing
- Reset values:
  - In_ACK = 0, Out_SEND = 0, Out_DATA = 0.
  - Out_COUNT = 1.
  - Occupancy = 0, `ph` = 0.
- First cycle in which In_ACK can be 1: the 3rd rising edge after RESET falls (RUN entered).
- Latency: a token pushed at edge k can drive Out_SEND in cycle k+1 (one cycle through the FIFO).
- Throughput: one token per cycle in and out concurrently, provided the FIFO is neither full nor empty.
- In_ACK and Out_SEND are combinational from In_SEND and Out_RDY respectively, qualified by registered state only.

## Configuration
- STREAM_RELAY_STATS_EN defined adds three outputs:
  - stat_in[31:0]: counts In_ACK.
  - stat_out[31:0]: counts Out_SEND.
  - stat_drop[31:0]: counts decimated tokens.
- All three counters clear on RESET and wrap at 2^32.
- Without the macro the ports and counters do not exist, and data-path behaviour is identical.

## Structure
- Package stream_relay_pkg holds:
  - COUNT_W = 16 and the constant TOKEN_COUNT = 16'h1.
  - The start-up state enum (RST, KICK1, KICK2, RUN).
  - The DEPTH legality check, a power-of-two function.
- Sub-module stream_relay_fifo:
  - Parameters DATA_W and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Asynchronous reset.
- The top level holds the FSM, the phase counter, the handshake logic and the optional stats.

## Test plan
- Start-up:
  - Stimulus: release RESET with In_SEND=1 and Out_RDY=1 held.
  - Required: In_ACK=0 for the first 2 edges and 1 from the 3rd. The first token appears on Out_DATA one cycle later, with Out_COUNT=1.
- Streaming, DECIM=1, DEPTH=4:
  - Stimulus: 10 tokens 0x0001..0x000A with Out_RDY held at 1.
  - Required: the same 10 values out in order, one per cycle, with a 1-cycle lag.
- Back-pressure:
  - Stimulus: Out_RDY=0 while 6 tokens are offered.
  - Required: 4 are accepted, then In_ACK drops. Raising Out_RDY with In_SEND still 1 drains 0x1..0x4; new tokens resume only once the FIFO is not full.
- Decimation, DECIM=3:
  - Stimulus: inputs 0..8.
  - Required: outputs 0,3,6. Dropped tokens are acked even while the FIFO is full.
- Mid-stream reset:
  - Stimulus: assert RESET with 3 tokens buffered and ph=2.
  - Required: Out_SEND=0 immediately, the FIFO is empty and ph=0 after release. The next input is kept.
- STREAM_RELAY_STATS_EN build:
  - Stimulus: 9 inputs, DECIM=3.
  - Required: stat_in=9, stat_drop=6, stat_out=3.

Source files
------------

// File: rtl/stream_relay_pkg.sv
// Shared types and constants for the stream_relay token actor.
package stream_relay_pkg;

   localparam int                 COUNT_W     = 16;
   localparam logic [COUNT_W-1:0] TOKEN_COUNT = 16'h1;

   typedef enum logic [1:0] {
      RST,
      KICK1,
      KICK2,
      RUN
   } state_t;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/stream_relay_fifo.sv
// Small circular token buffer; head entry is shown on dout, last popped value is held while empty.
module stream_relay_fifo
   import stream_relay_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("stream_relay_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [DATA_W-1:0] r_last;
   logic              w_push;
   logic              w_pop;

   assign full   = (r_count == CW'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   // NOTE: storage has no reset; an entry is only ever read after it has been written.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout = empty ? r_last : r_mem[r_rd_ptr];

endmodule

// File: rtl/stream_relay.sv
// Decimating, buffered SEND/ACK/RDY/COUNT token relay.
// Optional feature: define STREAM_RELAY_STATS_EN to add stat_in/stat_out/stat_drop counters.
module stream_relay
   import stream_relay_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int DECIM  = 1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [DATA_W-1:0]  In_DATA,
   input  logic               In_SEND,
   input  logic [COUNT_W-1:0] In_COUNT,
   output logic               In_ACK,
   output logic [DATA_W-1:0]  Out_DATA,
   output logic               Out_SEND,
   input  logic               Out_RDY,
   input  logic               Out_ACK,
   output logic [COUNT_W-1:0] Out_COUNT
`ifdef STREAM_RELAY_STATS_EN
   ,
   output logic [31:0]        stat_in,
   output logic [31:0]        stat_out,
   output logic [31:0]        stat_drop
`endif
);

   localparam logic [7:0] PH_LAST = 8'(DECIM - 1);

   if (DECIM < 1 || DECIM > 255) begin : g_bad_decim
      $error("stream_relay: DECIM must be in 1..255");
   end

   state_t     r_state;
   logic       r_run;
   logic [7:0] r_ph;
   logic       w_full;
   logic       w_empty;
   logic       w_keep;
   logic       w_in_ack;
   logic       w_push;
   logic       w_out_send;
   logic       w_unused;

   // Start-up sequencer: two idle cycles after reset before tokens may flow.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= RST;
         r_run   <= 1'b0;
      end else begin
         case (r_state)
            RST:     r_state <= KICK1;
            KICK1:   r_state <= KICK2;
            KICK2: begin
               r_state <= RUN;
               r_run   <= 1'b1;
            end
            default: r_state <= RUN;
         endcase
      end
   end

   // Only phase-0 tokens need space; the rest are dropped and acked regardless of fill.
   assign w_keep     = (r_ph == 8'd0);
   assign w_in_ack   = r_run & In_SEND & (~w_keep | ~w_full);
   assign w_push     = w_in_ack & w_keep;
   assign w_out_send = r_run & ~w_empty & Out_RDY;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_ph <= 8'd0;
      end else if (w_in_ack) begin
         r_ph <= (r_ph == PH_LAST) ? 8'd0 : r_ph + 8'd1;
      end
   end

   stream_relay_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (w_push),
      .pop   (w_out_send),
      .din   (In_DATA),
      .dout  (Out_DATA),
      .full  (w_full),
      .empty (w_empty)
   );

   assign In_ACK    = w_in_ack;
   assign Out_SEND  = w_out_send;
   assign Out_COUNT = TOKEN_COUNT;
   assign w_unused  = ^{In_COUNT, Out_ACK};

`ifdef STREAM_RELAY_STATS_EN
   logic [31:0] r_stat_in;
   logic [31:0] r_stat_out;
   logic [31:0] r_stat_drop;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_stat_in   <= '0;
         r_stat_out  <= '0;
         r_stat_drop <= '0;
      end else begin
         if (w_in_ack)            r_stat_in   <= r_stat_in + 32'd1;
         if (w_out_send)          r_stat_out  <= r_stat_out + 32'd1;
         if (w_in_ack && !w_keep) r_stat_drop <= r_stat_drop + 32'd1;
      end
   end

   assign stat_in   = r_stat_in;
   assign stat_out  = r_stat_out;
   assign stat_drop = r_stat_drop;
`endif

endmodule

// File: tb/tb_stream_relay.sv
// Directed bench for stream_relay: a DECIM=1 relay and a DECIM=3 decimator, both DEPTH=4.
module tb_stream_relay;

   logic        CLK = 1'b0;
   logic        RESET;

   logic [15:0] a_in_data,  d_in_data;
   logic        a_in_send,  d_in_send;
   logic        a_in_ack,   d_in_ack;
   logic [15:0] a_out_data, d_out_data;
   logic        a_out_send, d_out_send;
   logic        a_out_rdy,  d_out_rdy;
   logic [15:0] a_out_cnt,  d_out_cnt;
`ifdef STREAM_RELAY_STATS_EN
   logic [31:0] a_st_in, a_st_out, a_st_drop;
   logic [31:0] d_st_in, d_st_out, d_st_drop;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   stream_relay #(.DATA_W(16), .DEPTH(4), .DECIM(1)) u_relay (
      .CLK       (CLK),
      .RESET     (RESET),
      .In_DATA   (a_in_data),
      .In_SEND   (a_in_send),
      .In_COUNT  (16'd0),
      .In_ACK    (a_in_ack),
      .Out_DATA  (a_out_data),
      .Out_SEND  (a_out_send),
      .Out_RDY   (a_out_rdy),
      .Out_ACK   (1'b0),
      .Out_COUNT (a_out_cnt)
`ifdef STREAM_RELAY_STATS_EN
      ,
      .stat_in   (a_st_in),
      .stat_out  (a_st_out),
      .stat_drop (a_st_drop)
`endif
   );

   stream_relay #(.DATA_W(16), .DEPTH(4), .DECIM(3)) u_decim (
      .CLK       (CLK),
      .RESET     (RESET),
      .In_DATA   (d_in_data),
      .In_SEND   (d_in_send),
      .In_COUNT  (16'd0),
      .In_ACK    (d_in_ack),
      .Out_DATA  (d_out_data),
      .Out_SEND  (d_out_send),
      .Out_RDY   (d_out_rdy),
      .Out_ACK   (1'b0),
      .Out_COUNT (d_out_cnt)
`ifdef STREAM_RELAY_STATS_EN
      ,
      .stat_in   (d_st_in),
      .stat_out  (d_st_out),
      .stat_drop (d_st_drop)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check handshakes at the falling edge, then cross the rising edge.
   task automatic cyc(input bit sel, input bit send, input logic [15:0] data, input bit rdy,
                      input bit e_ack, input bit e_osend, input logic [15:0] e_odata, input string tag);
      if (sel) begin
         d_in_send = send; d_in_data = data; d_out_rdy = rdy;
      end else begin
         a_in_send = send; a_in_data = data; a_out_rdy = rdy;
      end
      @(negedge CLK);
      chk({tag, "_ack"},   32'(sel ? d_in_ack : a_in_ack),     32'(e_ack));
      chk({tag, "_osend"}, 32'(sel ? d_out_send : a_out_send), 32'(e_osend));
      if (e_osend) chk({tag, "_odata"}, 32'(sel ? d_out_data : a_out_data), 32'(e_odata));
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET     = 1'b1;
      a_in_send = 1'b1; a_in_data = 16'h0001; a_out_rdy = 1'b1;
      d_in_send = 1'b0; d_in_data = 16'h0000; d_out_rdy = 1'b0;

      // Reset values, with In_SEND and Out_RDY already high on the relay.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ack",    32'(a_in_ack),   32'd0);
      chk("rst_osend",  32'(a_out_send), 32'd0);
      chk("rst_odata",  32'(a_out_data), 32'd0);
      chk("rst_count",  32'(a_out_cnt),  32'd1);
      chk("rst_dcount", 32'(d_out_cnt),  32'd1);
      chk("rst_ddata",  32'(d_out_data), 32'd0);
      @(posedge CLK);
      #1 RESET = 1'b0;

      // Start-up: edge 1 -> KICK1, edge 2 -> KICK2, edge 3 -> RUN.
      @(posedge CLK);
      #1;
      cyc(0, 1, 16'h0001, 1, 0, 0, 16'h0, "kick1");
      cyc(0, 1, 16'h0001, 1, 0, 0, 16'h0, "kick2");

      // Streaming 1..10 with Out_RDY high: each token leaves one cycle after it is accepted.
      for (int i = 1; i <= 10; i++)
         cyc(0, 1, 16'(i), 1, 1, (i > 1), 16'(i - 1), $sformatf("stream%0d", i));
      cyc(0, 0, 16'h0, 1, 0, 1, 16'h000A, "stream_last");
      @(negedge CLK);
      chk("hold_odata", 32'(a_out_data), 32'h000A);
      chk("hold_osend", 32'(a_out_send), 32'd0);
      chk("out_count",  32'(a_out_cnt),  32'd1);
      @(posedge CLK);
      #1;

      // Back-pressure: four accepted, then refused until a pop frees a slot.
      for (int i = 1; i <= 4; i++)
         cyc(0, 1, 16'(i), 0, 1, 0, 16'h0, $sformatf("bp_fill%0d", i));
      cyc(0, 1, 16'h0005, 0, 0, 0, 16'h0,    "bp_full_a");
      cyc(0, 1, 16'h0005, 0, 0, 0, 16'h0,    "bp_full_b");
      cyc(0, 1, 16'h0005, 1, 0, 1, 16'h0001, "bp_pop1");
      cyc(0, 1, 16'h0005, 1, 1, 1, 16'h0002, "bp_pop2");
      cyc(0, 1, 16'h0006, 1, 1, 1, 16'h0003, "bp_pop3");
      cyc(0, 0, 16'h0000, 1, 0, 1, 16'h0004, "bp_pop4");
      cyc(0, 0, 16'h0000, 1, 0, 1, 16'h0005, "bp_pop5");
      cyc(0, 0, 16'h0000, 1, 0, 1, 16'h0006, "bp_pop6");
      cyc(0, 0, 16'h0000, 1, 0, 0, 16'h0000, "bp_empty");

      // Decimation by 3 on inputs 0..8: keep 0, 3, 6.
      cyc(1, 1, 16'd0, 1, 1, 0, 16'h0, "dec0");
      cyc(1, 1, 16'd1, 1, 1, 1, 16'd0, "dec1");
      cyc(1, 1, 16'd2, 1, 1, 0, 16'h0, "dec2");
      cyc(1, 1, 16'd3, 1, 1, 0, 16'h0, "dec3");
      cyc(1, 1, 16'd4, 1, 1, 1, 16'd3, "dec4");
      cyc(1, 1, 16'd5, 1, 1, 0, 16'h0, "dec5");
      cyc(1, 1, 16'd6, 1, 1, 0, 16'h0, "dec6");
      cyc(1, 1, 16'd7, 1, 1, 1, 16'd6, "dec7");
      cyc(1, 1, 16'd8, 1, 1, 0, 16'h0, "dec8");
`ifdef STREAM_RELAY_STATS_EN
      chk("stat_in",   d_st_in,   32'd9);
      chk("stat_drop", d_st_drop, 32'd6);
      chk("stat_out",  d_st_out,  32'd3);
`endif

      // Buffer 0x20, 0x23, 0x26 and leave ph=2, then reset mid-stream.
      for (int i = 0; i < 8; i++)
         cyc(1, 1, 16'(16'h20 + i), 0, 1, 0, 16'h0, $sformatf("mr_fill%0d", i));
      d_in_send = 1'b1; d_in_data = 16'h0055; d_out_rdy = 1'b1;
      RESET = 1'b1;
      #1;
      chk("mr_osend", 32'(d_out_send), 32'd0);
      chk("mr_ack",   32'(d_in_ack),   32'd0);
      chk("mr_odata", 32'(d_out_data), 32'd0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      @(posedge CLK);
      #1;
      cyc(1, 1, 16'h0055, 1, 0, 0, 16'h0,    "mr_kick1");
      cyc(1, 1, 16'h0055, 1, 0, 0, 16'h0,    "mr_kick2");
      cyc(1, 1, 16'h0055, 1, 1, 0, 16'h0,    "mr_keep");
      cyc(1, 0, 16'h0000, 1, 0, 1, 16'h0055, "mr_out");

      // ph=1 now: kept tokens are 0x32, 0x35, 0x38, 0x3B; drops still acked once full.
      for (int i = 0; i < 14; i++)
         cyc(1, 1, 16'(16'h30 + i), 0, 1, 0, 16'h0, $sformatf("df_in%0d", i));
      cyc(1, 1, 16'h003E, 0, 0, 0, 16'h0,    "df_full");
      cyc(1, 1, 16'h003E, 1, 0, 1, 16'h0032, "df_pop1");
      cyc(1, 1, 16'h003E, 1, 1, 1, 16'h0035, "df_pop2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
